// File: rtl/rf_pkg.sv
// Register-file constants and write-port arbitration defaults shared across the RF slice.
// Latency: none (declarations only).
// Backpressure: n/a.
package rf_pkg;

    localparam int RF_ADDR_W = 4;
    localparam int RF_DATA_W = 16;

    // Register written by call instructions with the return address.
    localparam logic [RF_ADDR_W-1:0] LINK_REG = 4'd15;

    // Default secondary queue size and starvation limit for the write-port arbiter.
    localparam int ARB_DEPTH    = 2;
    localparam int ARB_MAX_WAIT = 4;

    // Which requester owns the RF write port in a given cycle.
    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_WB   = 2'd1,
        GNT_SEC  = 2'd2
    } grant_e;

endpackage

// File: rtl/rf_wr_port_arbiter_if.sv
// Bundle of the pipeline WB request, secondary write request and RF write port signals.
// Latency: none (wiring only).
// Backpressure: secondary side uses sec_vld/sec_rdy; pipeline side is frozen by stall_wb.
interface rf_wr_port_arbiter_if
    import rf_pkg::*;
#(
    parameter int ADDR_W = RF_ADDR_W,
    parameter int DATA_W = RF_DATA_W
);

    logic                   wb_we;
    logic [ADDR_W-1:0]      wb_addr;
    logic [DATA_W-1:0]      wb_data;
    logic                   sec_vld;
    logic [ADDR_W-1:0]      sec_addr;
    logic [DATA_W-1:0]      sec_data;
    logic                   sec_rdy;
    logic                   rf_we;
    logic [ADDR_W-1:0]      rf_waddr;
    logic [DATA_W-1:0]      rf_wdata;
    logic                   stall_wb;
    logic [(1<<ADDR_W)-1:0] pend_mask;

    // Requesters / RF / hazard unit side.
    modport master (
        output wb_we, wb_addr, wb_data, sec_vld, sec_addr, sec_data,
        input  sec_rdy, rf_we, rf_waddr, rf_wdata, stall_wb, pend_mask
    );

    // Arbiter side.
    modport slave (
        input  wb_we, wb_addr, wb_data, sec_vld, sec_addr, sec_data,
        output sec_rdy, rf_we, rf_waddr, rf_wdata, stall_wb, pend_mask
    );

endinterface

// File: rtl/rf_wr_fifo.sv
// Small circular queue of pending secondary RF writes, exposing every valid entry's address.
// Latency: entry visible at the head the cycle after push; no bypass.
// Backpressure: push ignored while full, pop ignored while empty.
module rf_wr_fifo #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 16,
    parameter int DEPTH  = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [ADDR_W-1:0]            push_addr,
    input  logic [DATA_W-1:0]            push_data,
    input  logic                         pop,
    output logic                         full,
    output logic                         empty,
    output logic [ADDR_W-1:0]            head_addr,
    output logic [DATA_W-1:0]            head_data,
    output logic [DEPTH-1:0]             entry_vld,
    output logic [DEPTH-1:0][ADDR_W-1:0] entry_addr
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0]             wr_ptr;
    logic [PTR_W-1:0]             rd_ptr;
    logic [DEPTH-1:0]             vld;
    logic [DEPTH-1:0][ADDR_W-1:0] addr_mem;
    logic [DATA_W-1:0]            data_mem [DEPTH];
    logic                         do_push;
    logic                         do_pop;

    // Per-slot valid bits make full/empty and the pending mask trivial.
    assign full    = &vld;
    assign empty   = ~|vld;
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    assign head_addr  = addr_mem[rd_ptr];
    assign head_data  = data_mem[rd_ptr];
    assign entry_vld  = vld;
    assign entry_addr = addr_mem;

    // Occupancy and pointers; DEPTH is a power of two so pointers wrap naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            vld    <= '0;
        end else begin
            if (do_pop) begin
                vld[rd_ptr] <= 1'b0;
                rd_ptr      <= rd_ptr + 1'b1;
            end
            if (do_push) begin
                vld[wr_ptr] <= 1'b1;
                wr_ptr      <= wr_ptr + 1'b1;
            end
        end
    end

    // Payload storage; contents are only meaningful where the valid bit is set.
    always_ff @(posedge clk) begin
        if (do_push) begin
            addr_mem[wr_ptr] <= push_addr;
            data_mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/rf_wr_port_arbiter.sv
// Shares the RF write port between the WB stage (priority) and a queued secondary requester.
// Latency: grant registered onto rf_* one cycle later; secondary entries never bypass the queue.
// Backpressure: sec_rdy = !full; a starved queue head forces a one-cycle stall_wb pulse.
module rf_wr_port_arbiter
    import rf_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W,
    parameter int ADDR_W   = RF_ADDR_W,
    parameter int DEPTH    = ARB_DEPTH,
    parameter int MAX_WAIT = ARB_MAX_WAIT
) (
    input  logic                clk,
    input  logic                rst,
    rf_wr_port_arbiter_if.slave bus
);

    localparam int NREG   = 1 << ADDR_W;
    localparam int WAIT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

    logic                         fifo_full;
    logic                         fifo_empty;
    logic [ADDR_W-1:0]            head_addr;
    logic [DATA_W-1:0]            head_data;
    logic [DEPTH-1:0]             entry_vld;
    logic [DEPTH-1:0][ADDR_W-1:0] entry_addr;
    logic                         push;
    logic                         pop;

    grant_e                       grant;
    logic                         head_blocked;
    logic [WAIT_W-1:0]            wait_cnt;
    logic [WAIT_W-1:0]            wait_nxt;
    logic                         stall_nxt;

    logic                         rf_we_q;
    logic [ADDR_W-1:0]            rf_waddr_q;
    logic [DATA_W-1:0]            rf_wdata_q;
    logic                         stall_wb_q;
    logic [NREG-1:0]              pend;

    assign push = bus.sec_vld & ~fifo_full;
    assign pop  = (grant == GNT_SEC);

    rf_wr_fifo #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_addr  (bus.sec_addr),
        .push_data  (bus.sec_data),
        .pop        (pop),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .head_addr  (head_addr),
        .head_data  (head_data),
        .entry_vld  (entry_vld),
        .entry_addr (entry_addr)
    );

    // Port owner this cycle: a forced stall hands the slot to the queue head, else WB wins.
    always_comb begin
        grant = GNT_NONE;
        if (stall_wb_q && !fifo_empty) begin
            grant = GNT_SEC;
        end else if (bus.wb_we) begin
            grant = GNT_WB;
        end else if (!fifo_empty) begin
            grant = GNT_SEC;
        end
    end

    // Starvation tracking: count consecutive cycles the head loses to WB, stall on the last one.
    always_comb begin
        wait_nxt     = '0;
        stall_nxt    = 1'b0;
        head_blocked = !fifo_empty && bus.wb_we && !pop;
        if (head_blocked) begin
            if (wait_cnt == WAIT_LAST) begin
                stall_nxt = 1'b1;
            end else begin
                wait_nxt = wait_cnt + 1'b1;
            end
        end
    end

    // Registered write port, stall pulse and wait counter; address/data hold when idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            stall_wb_q <= 1'b0;
            wait_cnt   <= '0;
        end else begin
            rf_we_q    <= (grant != GNT_NONE);
            stall_wb_q <= stall_nxt;
            wait_cnt   <= wait_nxt;
            if (grant == GNT_WB) begin
                rf_waddr_q <= bus.wb_addr;
                rf_wdata_q <= bus.wb_data;
            end else if (grant == GNT_SEC) begin
                rf_waddr_q <= head_addr;
                rf_wdata_q <= head_data;
            end
        end
    end

    // Hazard mask: one bit per register targeted by any still-queued entry.
    always_comb begin
        pend = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entry_vld[i]) begin
                pend[entry_addr[i]] = 1'b1;
            end
        end
    end

    assign bus.sec_rdy   = ~fifo_full;
    assign bus.rf_we     = rf_we_q;
    assign bus.rf_waddr  = rf_waddr_q;
    assign bus.rf_wdata  = rf_wdata_q;
    assign bus.stall_wb  = stall_wb_q;
    assign bus.pend_mask = pend;

endmodule
